// File: rtl/spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : spi_flash_responder
// Brief    : Single-lane SPI flash target that serves 0x03 read and 0x0B fast
//            read from a byte-wide memory port. SPI pins are oversampled in
//            the system clock domain.
// Revision : 1.0 - initial release
// ============================================================================
module spi_flash_responder #(
  parameter int ADDR_BITS    = 16,
  parameter int DUMMY_CYCLES = 8
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 flash_csb,
  input  logic                 flash_clk,
  input  logic                 flash_io0,
  output logic                 flash_io1_do,
  output logic                 flash_io1_oe,
  output logic                 mem_rd,
  output logic [ADDR_BITS-1:0] mem_addr,
  input  logic [7:0]           mem_rdata,
  output logic                 busy
);

  localparam logic [2:0] c_st_idle   = 3'd0;
  localparam logic [2:0] c_st_cmd    = 3'd1;
  localparam logic [2:0] c_st_addr   = 3'd2;
  localparam logic [2:0] c_st_dummy  = 3'd3;
  localparam logic [2:0] c_st_data   = 3'd4;
  localparam logic [2:0] c_st_ignore = 3'd5;

  localparam logic [7:0] c_op_read = 8'h03;
  localparam logic [7:0] c_op_fast = 8'h0B;

  localparam logic [5:0] c_cmd_last   = 6'd7;
  localparam logic [5:0] c_addr_last  = 6'd23;
  localparam logic [5:0] c_byte_last  = 6'd7;
  localparam logic       c_has_dummy  = (DUMMY_CYCLES > 0);
  localparam logic [5:0] c_dummy_last = c_has_dummy ? 6'(DUMMY_CYCLES - 1) : 6'd0;

  // synchronizers and edge detect
  logic [1:0] r_csb_s;
  logic [1:0] r_sck_s;
  logic [1:0] r_mosi_s;
  logic       r_sck_d;
  logic       w_csb;
  logic       w_sck;
  logic       w_mosi;
  logic       w_rise;
  logic       w_fall;

  // control and datapath
  logic [2:0]           r_state;
  logic [2:0]           w_state_nx;
  logic [6:0]           r_cmd_sr;
  logic                 r_fast;
  logic [5:0]           r_bit_cnt;
  logic [ADDR_BITS-1:0] r_addr;
  logic [7:0]           r_tx_sr;
  logic                 r_do;
  logic                 r_oe;
  logic                 r_rd;
  logic                 r_ld;
  logic [7:0]           w_cmd_byte;
  logic [ADDR_BITS-1:0] w_addr_shift;

  assign w_csb        = r_csb_s[1];
  assign w_sck        = r_sck_s[1];
  assign w_mosi       = r_mosi_s[1];
  assign w_rise       = w_sck & ~r_sck_d;
  assign w_fall       = ~w_sck & r_sck_d;
  assign w_cmd_byte   = {r_cmd_sr, w_mosi};
  // Upper SPI address bits simply fall off the top of the shift register.
  assign w_addr_shift = {r_addr[ADDR_BITS-2:0], w_mosi};

  // Two-flop synchronizers for all pins plus one delay stage on the SPI clock
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_csb_s  <= 2'b11;
      r_sck_s  <= 2'b00;
      r_mosi_s <= 2'b00;
      r_sck_d  <= 1'b0;
    end else begin
      r_csb_s  <= {r_csb_s[0], flash_csb};
      r_sck_s  <= {r_sck_s[0], flash_clk};
      r_mosi_s <= {r_mosi_s[0], flash_io0};
      r_sck_d  <= r_sck_s[1];
    end
  end

  // State register
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= c_st_idle;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state decode; a deasserted chip select overrides any edge this cycle
  always_comb begin
    w_state_nx = r_state;
    if (w_csb) begin
      w_state_nx = c_st_idle;
    end else begin
      case (r_state)
        c_st_idle: w_state_nx = c_st_cmd;
        c_st_cmd: begin
          if (w_rise && (r_bit_cnt == c_cmd_last)) begin
            if ((w_cmd_byte == c_op_read) || (w_cmd_byte == c_op_fast)) begin
              w_state_nx = c_st_addr;
            end else begin
              w_state_nx = c_st_ignore;
            end
          end
        end
        c_st_addr: begin
          if (w_rise && (r_bit_cnt == c_addr_last)) begin
            w_state_nx = (r_fast && c_has_dummy) ? c_st_dummy : c_st_data;
          end
        end
        c_st_dummy: begin
          if (w_rise && (r_bit_cnt == c_dummy_last)) begin
            w_state_nx = c_st_data;
          end
        end
        default: w_state_nx = r_state;
      endcase
    end
  end

  // Shift registers, bit counter, memory strobe and MISO driver
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_cmd_sr  <= '0;
      r_fast    <= 1'b0;
      r_bit_cnt <= '0;
      r_addr    <= '0;
      r_tx_sr   <= '0;
      r_do      <= 1'b0;
      r_oe      <= 1'b0;
      r_rd      <= 1'b0;
      r_ld      <= 1'b0;
    end else begin
      r_rd <= 1'b0;
      if (w_csb) begin
        r_oe      <= 1'b0;
        r_bit_cnt <= '0;
        r_tx_sr   <= '0;
        r_ld      <= 1'b0;
      end else begin
        // Memory answers one cycle after the strobe; capture it then.
        r_ld <= r_rd;
        if (r_ld) begin
          r_tx_sr <= mem_rdata;
        end
        case (r_state)
          c_st_idle: r_bit_cnt <= '0;
          c_st_cmd: begin
            if (w_rise) begin
              r_cmd_sr <= w_cmd_byte[6:0];
              if (r_bit_cnt == c_cmd_last) begin
                r_bit_cnt <= '0;
                r_fast    <= (w_cmd_byte == c_op_fast);
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end
          c_st_addr: begin
            if (w_rise) begin
              r_addr <= w_addr_shift;
              if (r_bit_cnt == c_addr_last) begin
                r_bit_cnt <= '0;
                r_rd      <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end
          c_st_dummy: begin
            if (w_rise) begin
              r_bit_cnt <= (r_bit_cnt == c_dummy_last) ? 6'd0 : r_bit_cnt + 6'd1;
            end
          end
          c_st_data: begin
            if (w_fall) begin
              r_do    <= r_tx_sr[7];
              r_tx_sr <= {r_tx_sr[6:0], 1'b0};
              r_oe    <= 1'b1;
            end
            // Prefetch the next byte as soon as the host samples bit 0.
            if (w_rise) begin
              if (r_bit_cnt == c_byte_last) begin
                r_bit_cnt <= '0;
                r_addr    <= r_addr + 1'b1;
                r_rd      <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + 6'd1;
              end
            end
          end
          default: r_bit_cnt <= r_bit_cnt;
        endcase
      end
    end
  end

  // Output decode
  always_comb begin
    busy         = (r_state != c_st_idle);
    flash_io1_do = r_do;
    flash_io1_oe = r_oe;
    mem_rd       = r_rd;
    mem_addr     = r_addr;
  end

endmodule
`default_nettype wire

// File: tb/tb_spi_flash_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_spi_flash_responder
// Brief    : Self-checking bench for spi_flash_responder (SPI at clk/8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_flash_responder;

  logic        clk = 1'b0;
  logic        resetn;
  logic        flash_csb;
  logic        flash_clk;
  logic        flash_io0;
  logic        flash_io1_do;
  logic        flash_io1_oe;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_rdata = 8'h00;
  logic        busy;

  int   checks  = 0;
  int   passes  = 0;
  int   strobes = 0;
  int   oe_viol = 0;
  logic oe_allowed = 1'b0;
  logic prev_rd    = 1'b0;

  logic [15:0] addr_q[$];
  logic [7:0]  exp_q[$];

  typedef struct {
    logic [7:0]       cmd;
    logic [23:0]      addr;
    int               ndummy;
    int               nbytes;
    logic [3:0][7:0]  exp;
  } vec_t;

  vec_t vecs[6];

  always #5 clk = ~clk;

  spi_flash_responder #(.ADDR_BITS(16), .DUMMY_CYCLES(8)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .flash_csb    (flash_csb),
    .flash_clk    (flash_clk),
    .flash_io0    (flash_io0),
    .flash_io1_do (flash_io1_do),
    .flash_io1_oe (flash_io1_oe),
    .mem_rd       (mem_rd),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .busy         (busy)
  );

  // memory[i] = i ^ 0xA5, one cycle read latency
  always @(posedge clk) begin
    if (mem_rd) mem_rdata <= mem_addr[7:0] ^ 8'hA5;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Monitor: every strobe is matched against the expected address queue
  always @(negedge clk) begin
    if (flash_io1_oe && !oe_allowed) oe_viol++;
    if (mem_rd) begin
      strobes++;
      if (prev_rd) begin
        checks++;
        $display("FAIL mem_rd_width: got strobe longer than 1 cycle at addr %0h", mem_addr);
      end else if (addr_q.size() == 0) begin
        checks++;
        $display("FAIL mem_rd_unexpected: got strobe at addr %0h expected none", mem_addr);
      end else begin
        check("mem_addr", 32'(mem_addr), 32'(addr_q.pop_front()));
      end
    end
    prev_rd = mem_rd;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  task automatic spi_bit(input logic b, output logic r, output logic oe);
    flash_io0 = b;
    repeat (4) @(negedge clk);
    flash_clk = 1'b1;
    r  = flash_io1_do;
    oe = flash_io1_oe;
    repeat (4) @(negedge clk);
    flash_clk = 1'b0;
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx, output logic oe7);
    logic b, o;
    oe7 = 1'b0;
    for (int i = 7; i >= 0; i--) begin
      spi_bit(tx[i], b, o);
      rx[i] = b;
      if (i == 7) oe7 = o;
    end
  endtask

  task automatic check_byte(input string name, input logic [7:0] rx);
    if (exp_q.size() == 0) begin
      checks++;
      $display("FAIL %s: got byte %0h expected none", name, rx);
    end else begin
      check(name, 32'(rx), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic csb_begin();
    flash_csb = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic csb_end();
    repeat (4) @(negedge clk);
    flash_csb = 1'b1;
    repeat (4) @(negedge clk);
    oe_allowed = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic run_vec(input int idx);
    logic [7:0] rx;
    logic       oe_s, b, rd;
    int         s0;
    rd = (vecs[idx].cmd == 8'h03) || (vecs[idx].cmd == 8'h0B);
    if (rd) begin
      for (int i = 0; i <= vecs[idx].nbytes; i++)
        addr_q.push_back(vecs[idx].addr[15:0] + 16'(i));
    end
    for (int i = 0; i < vecs[idx].nbytes; i++) exp_q.push_back(vecs[idx].exp[i]);
    s0 = strobes;
    csb_begin();
    spi_byte(vecs[idx].cmd, rx, oe_s);
    spi_byte(vecs[idx].addr[23:16], rx, oe_s);
    spi_byte(vecs[idx].addr[15:8], rx, oe_s);
    spi_byte(vecs[idx].addr[7:0], rx, oe_s);
    for (int i = 0; i < vecs[idx].ndummy; i++) spi_bit(1'b1, b, oe_s);
    if (rd) oe_allowed = 1'b1;
    for (int i = 0; i < vecs[idx].nbytes; i++) begin
      spi_byte(8'h00, rx, oe_s);
      check($sformatf("v%0d_oe_byte%0d", idx, i), 32'(oe_s), 32'd1);
      check_byte($sformatf("v%0d_data_byte%0d", idx, i), rx);
    end
    csb_end();
    check($sformatf("v%0d_strobe_count", idx), 32'(strobes - s0),
          rd ? 32'(vecs[idx].nbytes + 1) : 32'd0);
  endtask

  initial begin
    logic [7:0] rx;
    logic       oe_s, b;
    int         s0;

    vecs[0] = '{cmd: 8'h03, addr: 24'h000010, ndummy: 0, nbytes: 4, exp: {8'hB6, 8'hB7, 8'hB4, 8'hB5}};
    vecs[1] = '{cmd: 8'h03, addr: 24'h00FFFE, ndummy: 0, nbytes: 4, exp: {8'hA4, 8'hA5, 8'h5A, 8'h5B}};
    vecs[2] = '{cmd: 8'h0B, addr: 24'h000020, ndummy: 8, nbytes: 4, exp: {8'h86, 8'h87, 8'h84, 8'h85}};
    vecs[3] = '{cmd: 8'h9F, addr: 24'h000000, ndummy: 8, nbytes: 0, exp: 32'h0};
    vecs[4] = '{cmd: 8'h03, addr: 24'h000005, ndummy: 0, nbytes: 1, exp: {24'h0, 8'hA0}};
    vecs[5] = '{cmd: 8'h03, addr: 24'hAB0040, ndummy: 0, nbytes: 2, exp: {16'h0, 8'hE4, 8'hE5}};

    flash_csb = 1'b1;
    flash_clk = 1'b0;
    flash_io0 = 1'b0;
    resetn    = 1'b0;
    repeat (4) @(negedge clk);
    check("reset_do",   32'(flash_io1_do), 32'd0);
    check("reset_oe",   32'(flash_io1_oe), 32'd0);
    check("reset_rd",   32'(mem_rd),       32'd0);
    check("reset_addr", 32'(mem_addr),     32'd0);
    check("reset_busy", 32'(busy),         32'd0);
    resetn = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 4; i++) run_vec(i);

    // Abort after 12 address bits: busy must drop exactly 3 cycles after csb
    s0 = strobes;
    csb_begin();
    spi_byte(8'h03, rx, oe_s);
    spi_byte(8'h00, rx, oe_s);
    for (int i = 0; i < 4; i++) spi_bit(1'b0, b, oe_s);
    repeat (4) @(negedge clk);
    check("abort_busy_before", 32'(busy), 32'd1);
    flash_csb = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_busy_2cyc", 32'(busy), 32'd1);
    @(negedge clk);
    check("abort_busy_3cyc", 32'(busy), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_no_strobe", 32'(strobes - s0), 32'd0);
    run_vec(4);

    // Asynchronous reset during the second data byte
    addr_q.push_back(16'h0030);
    addr_q.push_back(16'h0031);
    exp_q.push_back(8'h95);
    csb_begin();
    spi_byte(8'h03, rx, oe_s);
    spi_byte(8'h00, rx, oe_s);
    spi_byte(8'h00, rx, oe_s);
    spi_byte(8'h30, rx, oe_s);
    oe_allowed = 1'b1;
    spi_byte(8'h00, rx, oe_s);
    check_byte("rst_first_byte", rx);
    repeat (4) @(negedge clk);
    check("rst_pre_do",   32'(flash_io1_do), 32'd1);
    check("rst_pre_oe",   32'(flash_io1_oe), 32'd1);
    check("rst_pre_addr", 32'(mem_addr),     32'h31);
    resetn = 1'b0;
    #1;
    check("rst_async_do",   32'(flash_io1_do), 32'd0);
    check("rst_async_oe",   32'(flash_io1_oe), 32'd0);
    check("rst_async_rd",   32'(mem_rd),       32'd0);
    check("rst_async_addr", 32'(mem_addr),     32'd0);
    check("rst_async_busy", 32'(busy),         32'd0);
    oe_allowed = 1'b0;
    flash_csb  = 1'b1;
    flash_clk  = 1'b0;
    repeat (4) @(negedge clk);
    resetn = 1'b1;
    repeat (6) @(negedge clk);
    run_vec(5);

    check("addr_queue_drained", 32'(addr_q.size()), 32'd0);
    check("data_queue_drained", 32'(exp_q.size()),  32'd0);
    check("oe_outside_data",    32'(oe_viol),       32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
